// File: rtl/tdma_pkg.sv
// Shared definitions for the TDMA TXDP dispatch slice.
//   state_t      : dispatcher FSM states
//   SINGLE_RD/WR : IPIC-lite transaction type codes
//   AR_Q0_TXDP   : register address of queue 0's TXDP register
//   TXDP_STRIDE  : byte spacing between per-queue TXDP registers
//   txdp_addr()  : TXDP register address for a queue index
package tdma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RECYCLE,
    WAIT
  } state_t;

  localparam logic [2:0]  SINGLE_RD   = 3'd2;
  localparam logic [2:0]  SINGLE_WR   = 3'd3;
  localparam logic [31:0] AR_Q0_TXDP  = 32'h0000_0800;
  localparam logic [31:0] TXDP_STRIDE = 32'd4;

  function automatic logic [31:0] txdp_addr(input logic [3:0] q);
    return AR_Q0_TXDP + TXDP_STRIDE * {28'd0, q};
  endfunction

endpackage

// File: rtl/tdma_rr_arbiter.sv
// Combinational round-robin search: returns the first set bit of req at or
// after ptr, wrapping modulo NUM_QUEUES.
//   req       : per-queue request vector
//   ptr       : search start index (must be < NUM_QUEUES)
//   gnt_idx   : granted queue index (0 when nothing granted)
//   gnt_valid : some request was found
module tdma_rr_arbiter
  import tdma_pkg::*;
#(
  parameter int unsigned NUM_QUEUES = 8
) (
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [3:0]            ptr,
  output logic [3:0]            gnt_idx,
  output logic                  gnt_valid
);

  logic [NUM_QUEUES-1:0] req_rot;
  int unsigned           sum;

  always_comb begin
    // Rotate so that bit 0 corresponds to queue ptr; a fixed priority scan
    // from bit 0 is then the round-robin search.
    req_rot   = NUM_QUEUES'({req, req} >> ptr);
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    sum       = 0;
    for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
      if (!gnt_valid && req_rot[i]) begin
        sum = int'(ptr) + i;
        if (sum >= NUM_QUEUES) sum = sum - NUM_QUEUES;
        gnt_valid = 1'b1;
        gnt_idx   = 4'(sum);
      end
    end
  end

endmodule

// File: rtl/tdma_txdp_dispatch.sv
// Multi-queue TXDP dispatcher. Counts per-queue send requests, serves queues
// in round-robin order, pops a descriptor from the served queue's FIFO,
// writes it to that queue's TXDP register over IPIC-lite, and pushes the
// descriptor back to the FIFO.
//   clk, reset                    : clock, async active-high reset
//   send_req, clear_err           : request pulses, sticky-error clear
//   txfifo_*                      : descriptor FIFO pop / push-back handshake
//   ipic_*, write_addr/data_lite  : IPIC-lite single-write master interface
//   pending_cnt, active_q, busy   : status
//   overflow_err, timeout_err     : sticky error flags
module tdma_txdp_dispatch
  import tdma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_QUEUES     = 8,
  parameter int unsigned CNT_WIDTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES-1:0]            send_req,
  input  logic                             clear_err,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] txfifo_dread,
  input  logic [NUM_QUEUES-1:0]            txfifo_valid,
  output logic [NUM_QUEUES-1:0]            txfifo_rd_en,
  output logic [NUM_QUEUES-1:0]            txfifo_wr_start,
  output logic [DATA_WIDTH-1:0]            txfifo_wr_data,
  input  logic [NUM_QUEUES-1:0]            txfifo_wr_done,
  output logic [2:0]                       ipic_type_lite,
  output logic                             ipic_start_lite,
  input  logic                             ipic_done_lite_wire,
  output logic [ADDR_WIDTH-1:0]            write_addr_lite,
  output logic [DATA_WIDTH-1:0]            write_data_lite,
  output logic [NUM_QUEUES*CNT_WIDTH-1:0]  pending_cnt,
  output logic [3:0]                       active_q,
  output logic                             busy,
  output logic [NUM_QUEUES-1:0]            overflow_err,
  output logic                             timeout_err
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_Q   = 4'(NUM_QUEUES - 1);

  state_t                  state_q, state_d;
  logic [3:0]              active_q_q, active_q_d;
  logic [3:0]              ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_QUEUES];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]   rd_en_q, rd_en_d;
  logic [NUM_QUEUES-1:0]   wr_start_q, wr_start_d;
  logic [NUM_QUEUES-1:0]   ovf_q, ovf_d;
  logic                    tmo_err_q, tmo_err_d;
  logic                    ipic_start_q, ipic_start_d;
  logic [2:0]              ipic_type_q, ipic_type_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ipic_seen_q, ipic_seen_d;
  logic                    fifo_seen_q, fifo_seen_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  logic [NUM_QUEUES-1:0]   req_vec;
  logic [NUM_QUEUES-1:0]   act_oh;
  logic [3:0]              gnt_idx;
  logic                    gnt_valid;
  logic                    sel_valid, sel_wr_done;
  logic [DATA_WIDTH-1:0]   head;
  logic [3:0]              ptr_next;
  logic                    finish, tmo_hit;

  tdma_rr_arbiter #(.NUM_QUEUES(NUM_QUEUES)) u_arb (
    .req       (req_vec),
    .ptr       (ptr_q),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    act_oh      = NUM_QUEUES'(1) << active_q_q;
    sel_valid   = |(txfifo_valid & act_oh);
    sel_wr_done = |(txfifo_wr_done & act_oh);
    ptr_next    = (active_q_q == LAST_Q) ? 4'd0 : active_q_q + 4'd1;
    head        = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      req_vec[q] = (cnt_q[q] != '0);
      if (act_oh[q]) head = txfifo_dread[q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    active_q_d   = active_q_q;
    ptr_d        = ptr_q;
    rd_en_d      = '0;
    wr_start_d   = '0;
    ipic_start_d = ipic_start_q;
    ipic_type_d  = ipic_type_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    ipic_seen_d  = ipic_seen_q;
    fifo_seen_d  = fifo_seen_q;
    tmo_d        = tmo_q;
    finish       = 1'b0;
    tmo_hit      = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          active_q_d = gnt_idx;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        if (sel_valid) begin
          rd_en_d      = act_oh;
          wdata_d      = head;
          waddr_d      = ADDR_WIDTH'(txdp_addr(active_q_q));
          ipic_type_d  = SINGLE_WR;
          ipic_start_d = 1'b1;
          ipic_seen_d  = 1'b0;
          fifo_seen_d  = 1'b0;
          tmo_d        = '0;
          state_d      = RECYCLE;
        end else begin
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      RECYCLE, WAIT: begin
        // Completions are captured from RECYCLE on, so a done that arrives
        // alongside the push-back strobe still counts.
        tmo_d = tmo_q + TMO_W'(1);
        if (ipic_done_lite_wire) begin
          ipic_seen_d  = 1'b1;
          ipic_start_d = 1'b0;
        end
        if (sel_wr_done) fifo_seen_d = 1'b1;
        if (state_q == RECYCLE) begin
          wr_start_d = act_oh;
          state_d    = WAIT;
        end else if (ipic_seen_d && fifo_seen_d) begin
          finish = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          tmo_hit      = 1'b1;
          ipic_start_d = 1'b0;
        end
        if (finish || tmo_hit) begin
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tmo_err_d = (clear_err ? 1'b0 : tmo_err_q) | tmo_hit;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      logic inc, dec, sat;
      sat      = (cnt_q[q] == '1);
      inc      = send_req[q] && !sat;
      dec      = (finish || tmo_hit) && act_oh[q];
      cnt_d[q] = cnt_q[q];
      if (inc && !dec)      cnt_d[q] = cnt_q[q] + CNT_WIDTH'(1);
      else if (dec && !inc) cnt_d[q] = cnt_q[q] - CNT_WIDTH'(1);
      ovf_d[q] = (clear_err ? 1'b0 : ovf_q[q]) | (send_req[q] && sat);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      active_q_q   <= '0;
      ptr_q        <= '0;
      rd_en_q      <= '0;
      wr_start_q   <= '0;
      ovf_q        <= '0;
      tmo_err_q    <= 1'b0;
      ipic_start_q <= 1'b0;
      ipic_type_q  <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      ipic_seen_q  <= 1'b0;
      fifo_seen_q  <= 1'b0;
      tmo_q        <= '0;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= '0;
    end else begin
      state_q      <= state_d;
      active_q_q   <= active_q_d;
      ptr_q        <= ptr_d;
      rd_en_q      <= rd_en_d;
      wr_start_q   <= wr_start_d;
      ovf_q        <= ovf_d;
      tmo_err_q    <= tmo_err_d;
      ipic_start_q <= ipic_start_d;
      ipic_type_q  <= ipic_type_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      ipic_seen_q  <= ipic_seen_d;
      fifo_seen_q  <= fifo_seen_d;
      tmo_q        <= tmo_d;
      for (int unsigned q = 0; q < NUM_QUEUES; q++) cnt_q[q] <= cnt_d[q];
    end
  end

  always_comb begin
    pending_cnt = '0;
    for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
      pending_cnt[q*CNT_WIDTH +: CNT_WIDTH] = cnt_q[q];
    end
  end

  assign txfifo_rd_en    = rd_en_q;
  assign txfifo_wr_start = wr_start_q;
  assign txfifo_wr_data  = wdata_q;
  assign write_data_lite = wdata_q;
  assign write_addr_lite = waddr_q;
  assign ipic_type_lite  = ipic_type_q;
  assign ipic_start_lite = ipic_start_q;
  assign active_q        = active_q_q;
  assign busy            = (state_q != IDLE);
  assign overflow_err    = ovf_q;
  assign timeout_err     = tmo_err_q;

endmodule

// File: tb/tb_tdma_txdp_dispatch.sv
// Bench for tdma_txdp_dispatch: FIFO / IPIC-lite responders with
// programmable latencies, a scoreboard of expected dispatches in service
// order, a table of single-queue transactions and hand-written corner cases.
module tb_tdma_txdp_dispatch;

  localparam int NQ  = 8;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NQ-1:0]     send_req = '0;
  logic              clear_err = 1'b0;
  logic [NQ*32-1:0]  txfifo_dread;
  logic [NQ-1:0]     txfifo_valid = '1;
  logic [NQ-1:0]     txfifo_rd_en;
  logic [NQ-1:0]     txfifo_wr_start;
  logic [31:0]       txfifo_wr_data;
  logic [NQ-1:0]     txfifo_wr_done = '0;
  logic [2:0]        ipic_type_lite;
  logic              ipic_start_lite;
  logic              ipic_done_lite_wire = 1'b0;
  logic [31:0]       write_addr_lite;
  logic [31:0]       write_data_lite;
  logic [NQ*3-1:0]   pending_cnt;
  logic [3:0]        active_q;
  logic              busy;
  logic [NQ-1:0]     overflow_err;
  logic              timeout_err;

  tdma_txdp_dispatch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_QUEUES(NQ),
    .CNT_WIDTH(3), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .send_req(send_req), .clear_err(clear_err),
    .txfifo_dread(txfifo_dread), .txfifo_valid(txfifo_valid),
    .txfifo_rd_en(txfifo_rd_en), .txfifo_wr_start(txfifo_wr_start),
    .txfifo_wr_data(txfifo_wr_data), .txfifo_wr_done(txfifo_wr_done),
    .ipic_type_lite(ipic_type_lite), .ipic_start_lite(ipic_start_lite),
    .ipic_done_lite_wire(ipic_done_lite_wire),
    .write_addr_lite(write_addr_lite), .write_data_lite(write_data_lite),
    .pending_cnt(pending_cnt), .active_q(active_q), .busy(busy),
    .overflow_err(overflow_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  logic [31:0] heads [NQ];
  always_comb begin
    for (int q = 0; q < NQ; q++) txfifo_dread[q*32 +: 32] = heads[q];
  end

  // TXDP register map, written out literally.
  logic [31:0] txdp_tab [NQ] = '{32'h800, 32'h804, 32'h808, 32'h80C,
                                 32'h810, 32'h814, 32'h818, 32'h81C};

  typedef struct { int q; logic [31:0] data; logic [31:0] addr; } exp_t;
  exp_t sb [$];
  exp_t cur;

  int errors = 0;
  int checks = 0;
  int disp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pend(input int q);
    return 32'((pending_cnt >> (q*3)) & 24'h7);
  endfunction

  function automatic exp_t mk(input int q, input logic [31:0] d);
    exp_t e;
    e.q = q; e.data = d; e.addr = txdp_tab[q];
    return e;
  endfunction

  // Responders
  int ipic_lat = 1, wr_lat = 1, ipic_cnt = 0, wcnt = 0;
  bit ipic_en = 1'b1;
  logic [NQ-1:0] wpend = '0;

  always @(negedge clk) begin
    ipic_done_lite_wire = 1'b0;
    if (reset || !ipic_start_lite) ipic_cnt = 0;
    else if (ipic_en) begin
      ipic_cnt++;
      if (ipic_cnt == ipic_lat) ipic_done_lite_wire = 1'b1;
    end
  end

  always @(negedge clk) begin
    txfifo_wr_done = '0;
    if (reset) begin
      wpend = '0; wcnt = 0;
    end else begin
      if (txfifo_wr_start != '0) begin wpend = txfifo_wr_start; wcnt = 0; end
      if (wpend != '0) begin
        wcnt++;
        if (wcnt >= wr_lat) begin txfifo_wr_done = wpend; wpend = '0; end
      end
    end
  end

  // Scoreboard monitor
  logic [NQ-1:0] prev_rd = '0, prev_ws = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_rd = '0; prev_ws = '0;
    end else begin
      if (txfifo_rd_en != '0) begin
        check("rd_en_width", 32'(prev_rd), 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got rd_en 0x%0h expected none at %0t", txfifo_rd_en, $time);
        end else begin
          cur = sb.pop_front();
          disp_cnt++;
          check("rd_en_q", 32'(txfifo_rd_en), 32'(1 << cur.q));
          check("active_q", 32'(active_q), 32'(cur.q));
          check("txdp_addr", write_addr_lite, cur.addr);
          check("txdp_data", write_data_lite, cur.data);
          check("ipic_start", 32'(ipic_start_lite), 1);
          check("ipic_type", 32'(ipic_type_lite), 3);
        end
      end
      if (txfifo_wr_start != '0) begin
        check("wr_start_width", 32'(prev_ws), 0);
        check("wr_start_after_rd", 32'(prev_rd), 32'(1 << cur.q));
        check("wr_start_q", 32'(txfifo_wr_start), 32'(1 << cur.q));
        check("wr_data", txfifo_wr_data, cur.data);
      end
      prev_rd = txfifo_rd_en;
      prev_ws = txfifo_wr_start;
    end
  end

  task automatic drive_req(input logic [NQ-1:0] m);
    @(negedge clk) send_req = m;
    @(negedge clk) send_req = '0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || pending_cnt != '0) && n < budget);
    check("idle_reached", {30'd0, busy, pending_cnt != '0}, 0);
  endtask

  task automatic wait_rd_en(output int n);
    n = 0;
    while (txfifo_rd_en == '0 && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by 400000");
    $fatal(1, "watchdog");
  end

  typedef struct { int q; logic [31:0] head; int ilat; int wlat; } vec_t;

  initial begin
    vec_t tbl [5];
    int n, d0;
    logic seen;

    tbl[0] = '{6, 32'h1234_5600, 2, 2};
    tbl[1] = '{0, 32'hA5A5_0000, 1, 1};
    tbl[2] = '{3, 32'hDEAD_BEE0, 5, 1};
    tbl[3] = '{5, 32'hFFFF_FFFC, 3, 3};
    tbl[4] = '{7, 32'h0000_1F00, 1, 6};
    for (int q = 0; q < NQ; q++) heads[q] = 32'h1000_0000 + 32'(q * 16);

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_strobes", {16'd0, txfifo_rd_en, txfifo_wr_start}, 0);
    check("rst_ipic", {28'd0, ipic_start_lite, ipic_type_lite}, 0);
    check("rst_status", {3'd0, pending_cnt, active_q, busy}, 0);
    check("rst_addr", write_addr_lite, 0);
    check("rst_data", write_data_lite | txfifo_wr_data, 0);
    check("rst_err", {23'd0, overflow_err, timeout_err}, 0);
    @(negedge clk) reset = 1'b0;

    // Table of single-queue dispatches with assorted done orderings
    for (int i = 0; i < 5; i++) begin
      ipic_lat = tbl[i].ilat;
      wr_lat   = tbl[i].wlat;
      heads[tbl[i].q] = tbl[i].head;
      d0 = disp_cnt;
      sb.push_back(mk(tbl[i].q, tbl[i].head));
      @(negedge clk) send_req = NQ'(1 << tbl[i].q);
      @(negedge clk) send_req = '0;
      check("pend_after_req", pend(tbl[i].q), 1);
      wait_rd_en(n);
      check("req_to_rd_en", 32'(n), 2);
      wait_idle(100);
      check("disp_count", 32'(disp_cnt - d0), 1);
      check("pend_cleared", pend(tbl[i].q), 0);
    end

    // Round-robin 1,3,7 then late q1 behind q7
    ipic_lat = 1; wr_lat = 1;
    d0 = disp_cnt;
    sb.push_back(mk(1, heads[1]));
    sb.push_back(mk(3, heads[3]));
    sb.push_back(mk(7, heads[7]));
    sb.push_back(mk(1, heads[1]));
    drive_req(8'b1000_1010);
    n = 0;
    while (!(busy && active_q == 4'd3) && n < 60) begin @(negedge clk); n++; end
    check("q3_served", 32'(active_q), 3);
    drive_req(8'b0000_0010);
    wait_idle(200);
    check("rr_disp_count", 32'(disp_cnt - d0), 4);

    // Saturation on q2 with FIFO held empty
    txfifo_valid[2] = 1'b0;
    heads[2] = 32'h0000_2200;
    for (int i = 0; i < 8; i++) @(negedge clk) send_req = 8'h04;
    @(negedge clk) send_req = '0;
    check("sat_pend", pend(2), 7);
    check("sat_ovf", 32'(overflow_err), 32'h04);
    @(negedge clk) begin send_req = 8'h04; clear_err = 1'b1; end
    @(negedge clk) begin send_req = '0; clear_err = 1'b0; end
    check("ovf_beats_clear", 32'(overflow_err), 32'h04);
    check("sat_pend_hold", pend(2), 7);
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    check("ovf_cleared", 32'(overflow_err), 0);
    d0 = disp_cnt;
    for (int i = 0; i < 7; i++) sb.push_back(mk(2, 32'h0000_2200));
    txfifo_valid[2] = 1'b1;
    wait_idle(400);
    check("sat_disp_count", 32'(disp_cnt - d0), 7);

    // Empty FIFO on q4: no dispatch until valid rises
    txfifo_valid[4] = 1'b0;
    heads[4] = 32'h4444_0040;
    d0 = disp_cnt;
    drive_req(8'h10);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | ipic_start_lite | (txfifo_rd_en != '0);
    end
    check("empty_no_start", 32'(seen), 0);
    check("empty_pend", pend(4), 1);
    sb.push_back(mk(4, 32'h4444_0040));
    txfifo_valid[4] = 1'b1;
    wait_idle(100);
    check("empty_disp_count", 32'(disp_cnt - d0), 1);

    // IPIC never completes: timeout
    ipic_en = 1'b0; wr_lat = 1;
    heads[0] = 32'h0B0B_0000;
    sb.push_back(mk(0, 32'h0B0B_0000));
    drive_req(8'h01);
    n = 0;
    while (!ipic_start_lite && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (ipic_start_lite && n < 100) begin n++; @(negedge clk); end
    check("tmo_start_cycles", 32'(n), TMO);
    check("tmo_err_set", 32'(timeout_err), 1);
    check("tmo_pend", pend(0), 0);
    check("tmo_busy", 32'(busy), 0);
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    check("tmo_err_cleared", 32'(timeout_err), 0);

    // Reset while waiting for completion
    heads[5] = 32'h5555_0050;
    sb.push_back(mk(5, 32'h5555_0050));
    drive_req(8'h20);
    n = 0;
    while (txfifo_wr_start == '0 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    check("pre_rst_start", 32'(ipic_start_lite), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_strobes", {15'd0, txfifo_rd_en, txfifo_wr_start, ipic_start_lite}, 0);
    check("mid_rst_status", {3'd0, pending_cnt, active_q, busy}, 0);
    check("mid_rst_regs", write_addr_lite | write_data_lite, 0);
    check("mid_rst_type", 32'(ipic_type_lite), 0);
    @(negedge clk) reset = 1'b0;
    ipic_en = 1'b1;

    // Recovery after reset
    heads[3] = 32'h3333_0030;
    sb.push_back(mk(3, 32'h3333_0030));
    drive_req(8'h08);
    wait_idle(100);

    check("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
